// File: rtl/servo_pwm_decoder_if.sv
// Servo PWM decoder bundle: raw pulse input plus decoded width/period/position results.
interface servo_pwm_decoder_if;
    logic        pwm_in;
    logic [11:0] width_us;
    logic [15:0] period_us;
    logic [7:0]  pos;
    logic [2:0]  LEDS;
    logic        valid;
    logic        err;
    logic        lost;

    // master sources the pulse train and consumes results; slave is the decoder
    modport master (
        output pwm_in,
        input  width_us, period_us, pos, LEDS, valid, err, lost
    );
    modport slave (
        input  pwm_in,
        output width_us, period_us, pos, LEDS, valid, err, lost
    );
endinterface

// File: rtl/servo_pwm_decoder.sv
// Measures a servo-style pulse train and decodes the high width into a position code,
// with per-frame valid/err strobes and a signal-lost level.
module servo_pwm_decoder #(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned MIN_US     = 500,
    parameter int unsigned MAX_US     = 2500,
    parameter int unsigned PER_MIN_US = 15000,
    parameter int unsigned PER_MAX_US = 25000,
    parameter int unsigned TIMEOUT_US = 50000
) (
    input  logic               CLK,
    input  logic               RST_N,
    servo_pwm_decoder_if.slave bus
);

    localparam int unsigned      TICK_DIV = CLK_HZ / 1_000_000;
    localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [15:0] MIN_W   = 16'(MIN_US);
    localparam logic [15:0] MAX_W   = 16'(MAX_US);
    localparam logic [15:0] PMIN_W  = 16'(PER_MIN_US);
    localparam logic [15:0] PMAX_W  = 16'(PER_MAX_US);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_US - 1);

    localparam logic [1:0] StSync  = 2'd0;
    localparam logic [1:0] StArmed = 2'd1;
    localparam logic [1:0] StHigh  = 2'd2;
    localparam logic [1:0] StLow   = 2'd3;

    logic             sync1_q, sync2_q, prev_q;
    logic             rise_q, fall_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      us_q, us_d, us_inc;
    logic [15:0]      hi_q, hi_d;
    logic [1:0]       state_q, state_d;
    logic [11:0]      width_q, width_d;
    logic [15:0]      period_q, period_d;
    logic [7:0]       pos_q, pos_d, pos_new;
    logic [2:0]       leds_q, leds_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             lost_q, lost_d;
    logic             tick, timeout, clr, accept;

    // us_inc already counts the current cycle, so a pulse of exactly N us reads back as N
    always_comb begin
        tick    = (pre_q == PRE_LAST);
        us_inc  = (tick && us_q != 16'hFFFF) ? us_q + 16'd1 : us_q;
        timeout = tick && (us_q == TO_LAST);
        accept  = (hi_q >= MIN_W) && (hi_q <= MAX_W) && (us_inc >= PMIN_W) && (us_inc <= PMAX_W);
        pos_new = 8'((hi_q - MIN_W) >> 3);
    end

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        width_d  = width_q;
        period_d = period_q;
        pos_d    = pos_q;
        leds_d   = leds_q;
        lost_d   = lost_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        clr      = rise_q;
        unique case (state_q)
            StSync: begin
                if (timeout) begin
                    lost_d = 1'b1;
                    clr    = 1'b1;
                end
                if (!sync2_q) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // The first rise only starts the measurement; no frame is reported for it
                if (rise_q) begin
                    state_d = StHigh;
                end else if (timeout) begin
                    lost_d = 1'b1;
                    clr    = 1'b1;
                end
            end
            StHigh: begin
                if (fall_q) begin
                    hi_d    = us_inc;
                    state_d = StLow;
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    clr     = 1'b1;
                    state_d = StSync;
                end
            end
            StLow: begin
                if (rise_q) begin
                    state_d = StHigh;
                    if (accept) begin
                        width_d  = hi_q[11:0];
                        period_d = us_inc;
                        pos_d    = pos_new;
                        leds_d   = pos_new[7:5];
                        valid_d  = 1'b1;
                        lost_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timeout) begin
                    lost_d  = 1'b1;
                    clr     = 1'b1;
                    state_d = StSync;
                end
            end
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        pre_d = clr ? '0 : (tick ? '0 : pre_q + PRE_W'(1));
        us_d  = clr ? 16'd0 : us_inc;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            pre_q    <= '0;
            us_q     <= 16'd0;
            hi_q     <= 16'd0;
            state_q  <= StSync;
            width_q  <= 12'd0;
            period_q <= 16'd0;
            pos_q    <= 8'd0;
            leds_q   <= 3'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            sync1_q  <= bus.pwm_in;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            rise_q   <= sync2_q & ~prev_q;
            fall_q   <= ~sync2_q & prev_q;
            pre_q    <= pre_d;
            us_q     <= us_d;
            hi_q     <= hi_d;
            state_q  <= state_d;
            width_q  <= width_d;
            period_q <= period_d;
            pos_q    <= pos_d;
            leds_q   <= leds_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            lost_q   <= lost_d;
        end
    end

    assign bus.width_us  = width_q;
    assign bus.period_us = period_q;
    assign bus.pos       = pos_q;
    assign bus.LEDS      = leds_q;
    assign bus.valid     = valid_q;
    assign bus.err       = err_q;
    assign bus.lost      = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder using a scaled timebase (4 cycles per us).
module tb_servo_pwm_decoder;

    localparam int unsigned CLK_HZ = 4_000_000;
    localparam int D          = 4;
    localparam int MIN_US     = 50;
    localparam int MAX_US     = 250;
    localparam int PER_MIN_US = 300;
    localparam int PER_MAX_US = 500;
    localparam int TIMEOUT_US = 800;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    servo_pwm_decoder_if bus ();

    servo_pwm_decoder #(
        .CLK_HZ    (CLK_HZ),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .PER_MIN_US(PER_MIN_US),
        .PER_MAX_US(PER_MAX_US),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit ok;
        int at;
        int width;
        int period;
        int pos;
        int leds;
        bit lost;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: frames measured in drive cycles, converted to whole microseconds
    bit have_ref = 1'b0;
    int ref_t    = 0;
    int last_hi  = 0;
    int acc_w    = 0;
    int acc_p    = 0;
    int acc_pos  = 0;
    bit m_lost   = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rise_edge();
        int   hi;
        int   per;
        bit   ok;
        exp_t e;
        @(negedge CLK);
        bus.pwm_in = 1'b1;
        if (have_ref) begin
            hi  = last_hi;
            per = (cyc - ref_t) / D;
            ok  = (hi >= MIN_US) && (hi <= MAX_US) && (per >= PER_MIN_US) && (per <= PER_MAX_US);
            if (ok) begin
                acc_w   = hi;
                acc_p   = per;
                acc_pos = (hi - MIN_US) / 8;
                m_lost  = 1'b0;
            end
            e.ok     = ok;
            e.at     = cyc + 4;
            e.width  = acc_w;
            e.period = acc_p;
            e.pos    = acc_pos;
            e.leds   = acc_pos / 32;
            e.lost   = m_lost;
            sb_q.push_back(e);
        end
        have_ref = 1'b1;
        ref_t    = cyc;
    endtask

    task automatic fall_edge();
        @(negedge CLK);
        bus.pwm_in = 1'b0;
        last_hi    = (cyc - ref_t) / D;
    endtask

    // One pulse: high for h cycles, then low until p cycles after the rise
    task automatic frame(input int h, input int p);
        rise_edge();
        repeat (h - 1) @(negedge CLK);
        fall_edge();
        repeat (p - h - 1) @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_width"}, int'(bus.width_us), 0);
        check({tag, "_period"}, int'(bus.period_us), 0);
        check({tag, "_pos"}, int'(bus.pos), 0);
        check({tag, "_leds"}, int'(bus.LEDS), 0);
        check({tag, "_valid"}, int'(bus.valid), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_lost"}, int'(bus.lost), 1);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (bus.valid || bus.err) begin
                check("strobe_exclusive", int'(bus.valid & bus.err), 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: valid=%0d err=%0d at cycle %0d, expected none",
                             bus.valid, bus.err, cyc);
                end else begin
                    cur = sb_q.pop_front();
                    check("strobe_cycle", cyc, cur.at);
                    check("strobe_is_valid", int'(bus.valid), int'(cur.ok));
                    check("width_us", int'(bus.width_us), cur.width);
                    check("period_us", int'(bus.period_us), cur.period);
                    check("pos", int'(bus.pos), cur.pos);
                    check("leds", int'(bus.LEDS), cur.leds);
                    check("lost_at_strobe", int'(bus.lost), int'(cur.lost));
                end
            end
        end
    end

    initial begin
        bus.pwm_in = 1'b0;
        RST_N      = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);

        // Nominal train: first rise only arms
        frame(150 * D, 400 * D);
        check("lost_before_first_valid", int'(bus.lost), 1);
        frame(150 * D, 400 * D);
        frame(150 * D, 400 * D);

        // Width sweep and width boundaries
        frame(MIN_US * D, 400 * D);
        frame(MAX_US * D, 400 * D);
        frame(100 * D, 400 * D);
        frame(MIN_US * D - 1, 400 * D);
        frame(MAX_US * D + D - 1, 400 * D);
        frame(MAX_US * D + D, 400 * D);
        frame(150 * D, 400 * D);

        // Out-of-range frames, then period boundaries
        frame(40 * D, 400 * D);
        frame(260 * D, 400 * D);
        frame(150 * D, 600 * D);
        frame(150 * D, PER_MIN_US * D);
        frame(150 * D, PER_MIN_US * D - 1);
        frame(150 * D, PER_MAX_US * D + D - 1);
        frame(150 * D, PER_MAX_US * D + D);
        frame(150 * D, 400 * D);

        for (int i = 0; i < 12; i++) begin
            frame(int'($urandom_range(MAX_US * D + 40, MIN_US * D - 40)),
                  int'($urandom_range(PER_MAX_US * D + 60, PER_MIN_US * D - 60)));
        end

        // Stuck high: lost rises exactly TIMEOUT_US after the rise is seen
        frame(150 * D, 400 * D);
        frame(150 * D, 400 * D);
        rise_edge();
        repeat (3 + TIMEOUT_US * D) @(negedge CLK);
        check("lost_before_timeout", int'(bus.lost), 0);
        @(negedge CLK);
        check("lost_at_timeout", int'(bus.lost), 1);
        m_lost   = 1'b1;
        have_ref = 1'b0;
        repeat (100) @(negedge CLK);
        fall_edge();
        repeat (400) @(negedge CLK);
        frame(150 * D, 400 * D);
        check("lost_after_resume_rise", int'(bus.lost), 1);
        frame(150 * D, 400 * D);
        frame(120 * D, 420 * D);
        rise_edge();

        // Asynchronous reset in the middle of a high pulse
        repeat (20) @(negedge CLK);
        #2;
        RST_N      = 1'b0;
        bus.pwm_in = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        have_ref = 1'b0;
        acc_w    = 0;
        acc_p    = 0;
        acc_pos  = 0;
        m_lost   = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK);
        frame(200 * D, 450 * D);
        check("no_strobe_after_reset", sb_q.size(), 0);
        frame(200 * D, 450 * D);
        frame(75 * D, 350 * D);
        rise_edge();
        repeat (40) @(negedge CLK);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
